// File: rtl/bp_fe_queue_rolly.sv
`default_nettype none
//==============================================================================
// Module   : bp_fe_queue_rolly
// Purpose  : Front-end producer side of the FE->BE instruction queue. Buffers
//            fe_queue packets from the fetch pipeline and presents them to the
//            back end as a valid/yumi stream. Reads are speculative until the
//            back end commits them (deq). It can rewind them to the last commit
//            (roll) or drop everything not yet read (clr).
// Ports    : clk_i, reset_i            - clock, async active-high reset
//            fe_queue_i/_v_i/_ready_o  - FE write side (enq = v & ready & ~clr)
//            fe_queue_o/_v_o/_yumi_i   - BE read side (async read at rptr)
//            fe_queue_clr_i            - discard unread entries
//            fe_queue_deq_i            - commit read entries, freeing slots
//            fe_queue_roll_i           - rewind read pointer to commit pointer
// Revision : 1.0 - initial release
//==============================================================================
module bp_fe_queue_rolly #(
    parameter int width_p = 1,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,

    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,

    input  logic               fe_queue_clr_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i
);

    localparam int c_idx_w      = $clog2(els_p);
    localparam int ptr_width_lp = c_idx_w + 1;

    // Pointers carry one extra wrap bit above the slot index so that full and
    // empty can be told apart when the index bits coincide.
    logic [ptr_width_lp-1:0] r_wptr, r_rptr, r_cptr;
    logic [ptr_width_lp-1:0] w_wptr_n, w_rptr_n, w_cptr_n;
    logic [width_p-1:0]      r_mem [els_p];

    logic w_full, w_empty, w_enq;

    // Status comes from registered pointers only, so ready/valid have no
    // combinational path from any input.
    assign w_full  = (r_wptr[ptr_width_lp-1] != r_cptr[ptr_width_lp-1])
                   && (r_wptr[c_idx_w-1:0] == r_cptr[c_idx_w-1:0]);
    assign w_empty = (r_rptr == r_wptr);

    assign fe_queue_ready_o = ~w_full;
    assign fe_queue_v_o     = ~w_empty;
    assign fe_queue_o       = r_mem[r_rptr[c_idx_w-1:0]];

    // A clr cycle is a flush; any packet offered with it is dropped.
    assign w_enq = fe_queue_v_i & ~w_full & ~fe_queue_clr_i;

    always_comb begin
        w_rptr_n = r_rptr;
        w_cptr_n = r_cptr;
        w_wptr_n = r_wptr;

        // Roll takes precedence over a same-cycle yumi and deq.
        if (fe_queue_roll_i) begin
            w_rptr_n = r_cptr;
        end else if (fe_queue_yumi_i) begin
            w_rptr_n = r_rptr + 1'b1;
        end

        // An entry read in the same cycle as deq is part of the commit.
        if (!fe_queue_roll_i && fe_queue_deq_i) begin
            w_cptr_n = r_rptr + {{(ptr_width_lp-1){1'b0}}, fe_queue_yumi_i};
        end

        // Clear truncates the queue at the post-roll/yumi read point.
        if (fe_queue_clr_i) begin
            w_wptr_n = w_rptr_n;
        end else if (w_enq) begin
            w_wptr_n = r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else begin
            r_wptr <= w_wptr_n;
            r_rptr <= w_rptr_n;
            r_cptr <= w_cptr_n;
        end
    end

    // Storage is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[c_idx_w-1:0]] <= fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    logic [ptr_width_lp-1:0] w_occ, w_rd;
    assign w_occ = r_wptr - r_cptr;
    assign w_rd  = r_rptr - r_cptr;

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_queue_yumi_i |-> fe_queue_v_o)
        else $error("yumi asserted while fe_queue_v_o is low");

    a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
        w_enq |-> !w_full)
        else $error("enqueue while full");

    a_ptr_order: assert property (@(posedge clk_i) disable iff (reset_i)
        (w_rd <= w_occ) && (w_occ <= ptr_width_lp'(els_p)))
        else $error("pointer ordering violated");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_queue_rolly.sv
`default_nettype none
//==============================================================================
// Module   : tb_bp_fe_queue_rolly
// Purpose  : Self-checking bench for bp_fe_queue_rolly (els_p=4, width_p=8).
//            A queue-level reference model is compared against the DUT on
//            every falling edge; directed literal checks pin the model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_bp_fe_queue_rolly;

    localparam int ELS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_in = '0;
    logic       v_in = 1'b0;
    logic       ready_o;
    logic [7:0] data_o;
    logic       v_o;
    logic       yumi = 1'b0;
    logic       clr = 1'b0;
    logic       deq = 1'b0;
    logic       roll = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_fe_queue_rolly #(.width_p(8), .els_p(ELS)) dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .fe_queue_i      (d_in),
        .fe_queue_v_i    (v_in),
        .fe_queue_ready_o(ready_o),
        .fe_queue_o      (data_o),
        .fe_queue_v_o    (v_o),
        .fe_queue_yumi_i (yumi),
        .fe_queue_clr_i  (clr),
        .fe_queue_deq_i  (deq),
        .fe_queue_roll_i (roll)
    );

    // Reference model: q holds every uncommitted entry, oldest first;
    // nread of them (from the front) have been read but not committed.
    logic [7:0] q[$];
    int         nread;
    logic       m_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            nread = 0;
        end else begin
            m_rdy = (q.size() < ELS);
            if (roll)      nread = 0;
            else if (yumi) nread = nread + 1;
            if (!roll && deq) begin
                repeat (nread) void'(q.pop_front());
                nread = 0;
            end
            if (clr) begin
                while (q.size() > nread) void'(q.pop_back());
            end else if (v_in && m_rdy) begin
                q.push_back(d_in);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (ready_o !== (q.size() < ELS)) begin
                errors++;
                $display("FAIL model_ready t=%0t got=%b exp=%b", $time, ready_o, q.size() < ELS);
            end
            checks++;
            if (v_o !== (nread < q.size())) begin
                errors++;
                $display("FAIL model_valid t=%0t got=%b exp=%b", $time, v_o, nread < q.size());
            end
            if (nread < q.size()) begin
                checks++;
                if (data_o !== q[nread]) begin
                    errors++;
                    $display("FAIL model_data t=%0t got=%h exp=%h", $time, data_o, q[nread]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // One clock cycle with the given controls; returns just after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic y,
                        input logic c, input logic dq, input logic r);
        v_in = v; d_in = d; yumi = y; clr = c; deq = dq; roll = r;
        @(posedge clk);
        #1;
        v_in = 0; yumi = 0; clr = 0; deq = 0; roll = 0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1, d, 0, 0, 0, 0);
    endtask

    task automatic pop();
        step(0, 8'h00, 1, 0, 0, 0);
    endtask

    task automatic commit();
        step(0, 8'h00, 0, 0, 1, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_v", {7'b0, v_o}, 8'h00);
        chk("reset_ready", {7'b0, ready_o}, 8'h01);

        // Fill to full; the fifth push must be refused.
        push(8'h11);
        chk("first_v", {7'b0, v_o}, 8'h01);
        chk("first_data", data_o, 8'h11);
        push(8'h22); push(8'h33); push(8'h44);
        chk("full_ready", {7'b0, ready_o}, 8'h00);
        push(8'h55);
        chk("full_head", data_o, 8'h11);
        chk("full_ready2", {7'b0, ready_o}, 8'h00);

        // Read two, commit, refill across the wrap point, drain in order.
        pop();
        chk("read_22", data_o, 8'h22);
        pop();
        chk("read_33", data_o, 8'h33);
        chk("pre_deq_ready", {7'b0, ready_o}, 8'h00);
        commit();
        chk("deq_ready", {7'b0, ready_o}, 8'h01);
        push(8'h55); push(8'h66);
        chk("refull_ready", {7'b0, ready_o}, 8'h00);
        pop(); chk("read_44", data_o, 8'h44);
        pop(); chk("read_55", data_o, 8'h55);
        pop(); chk("read_66", data_o, 8'h66);
        pop(); chk("drain_v", {7'b0, v_o}, 8'h00);
        commit();

        // Roll replays uncommitted reads.
        push(8'hA1); push(8'hB2); push(8'hC3);
        pop(); pop();
        chk("pre_roll", data_o, 8'hC3);
        step(0, 8'h00, 0, 0, 0, 1);
        chk("roll_v", {7'b0, v_o}, 8'h01);
        chk("roll_data", data_o, 8'hA1);
        pop(); chk("replay_b", data_o, 8'hB2);
        pop(); chk("replay_c", data_o, 8'hC3);
        pop(); chk("replay_end", {7'b0, v_o}, 8'h00);
        commit();

        // Clear together with an offered packet: packet dropped.
        push(8'hA1); push(8'hB2); push(8'hC3);
        pop(); commit();
        step(1, 8'hDD, 0, 1, 0, 0);
        chk("clr_v", {7'b0, v_o}, 8'h00);
        chk("clr_ready", {7'b0, ready_o}, 8'h01);
        push(8'hEE);
        chk("after_clr", data_o, 8'hEE);
        pop(); commit();

        // Roll + clear: everything uncommitted vanishes, four slots free.
        push(8'h01); push(8'h02); push(8'h03);
        pop(); pop();
        step(0, 8'h00, 0, 1, 0, 1);
        chk("rollclr_v", {7'b0, v_o}, 8'h00);
        chk("rollclr_ready", {7'b0, ready_o}, 8'h01);
        push(8'h04); push(8'h05); push(8'h06);
        chk("three_ready", {7'b0, ready_o}, 8'h01);
        push(8'h07);
        chk("four_full", {7'b0, ready_o}, 8'h00);
        chk("four_head", data_o, 8'h04);
        pop(); pop();

        // Combined yumi + deq on the same cycle commits that entry.
        step(0, 8'h00, 1, 0, 1, 0);
        chk("yumi_deq_ready", {7'b0, ready_o}, 8'h01);
        chk("yumi_deq_data", data_o, 8'h07);

        // Asynchronous reset mid-stream with yumi asserted.
        yumi = 1;
        #2 rst = 1;
        #1;
        chk("async_v", {7'b0, v_o}, 8'h00);
        chk("async_ready", {7'b0, ready_o}, 8'h01);
        yumi = 0;
        @(posedge clk);
        #1 rst = 0;
        push(8'h77);
        chk("post_reset_v", {7'b0, v_o}, 8'h01);
        chk("post_reset_data", data_o, 8'h77);
        pop();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
